// File: rtl/fp_cvt_arbiter_if.sv
// fp_cvt_arbiter_if: request/result bus between two requesters, the shared converter and its consumer
// Signals: req0_*/req1_* (vld, int, tag in; rdy out), res_* (vld, fp, tag, src out; rdy in), cvt_cnt out.
// Modports: master = requesters + consumer side, slave = arbiter side.
interface fp_cvt_arbiter_if #(parameter int TAG_W = 4, parameter int CNT_W = 16);
  logic             req0_vld;
  logic [31:0]      req0_int;
  logic [TAG_W-1:0] req0_tag;
  logic             req0_rdy;
  logic             req1_vld;
  logic [31:0]      req1_int;
  logic [TAG_W-1:0] req1_tag;
  logic             req1_rdy;
  logic             res_vld;
  logic [31:0]      res_fp;
  logic [TAG_W-1:0] res_tag;
  logic             res_src;
  logic             res_rdy;
  logic [CNT_W-1:0] cvt_cnt;
  modport master (
    output req0_vld, req0_int, req0_tag, req1_vld, req1_int, req1_tag, res_rdy,
    input  req0_rdy, req1_rdy, res_vld, res_fp, res_tag, res_src, cvt_cnt
  );
  modport slave (
    input  req0_vld, req0_int, req0_tag, req1_vld, req1_int, req1_tag, res_rdy,
    output req0_rdy, req1_rdy, res_vld, res_fp, res_tag, res_src, cvt_cnt
  );
endinterface

// File: rtl/fp_cvt_arbiter.sv
// fp_cvt_arbiter: round-robin arbiter sharing one int32-to-float32 converter between two requesters
// Ports: clk, rst_n (async, active-low), bus (fp_cvt_arbiter_if.slave) carrying both request
// channels, the one-entry result register (res_*) and the consumed-result counter cvt_cnt.
module fp_cvt_arbiter #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  fp_cvt_arbiter_if.slave  bus
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e           state_q, state_d;
  logic [31:0]      fp_q, fp_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             free, gnt0, gnt1, gnt;
  logic [31:0]      sel_int, mag, norm, cvt;
  logic [TAG_W-1:0] sel_tag;
  logic [4:0]       msb;
  always_comb begin
    free = state_q == EMPTY || bus.res_rdy;
    // last_q=1 means requester 1 was granted most recently, so requester 0 wins a tie
    gnt0 = free && bus.req0_vld && (!bus.req1_vld || last_q);
    gnt1 = free && bus.req1_vld && (!bus.req0_vld || !last_q);
    gnt = gnt0 || gnt1;
    sel_int = gnt1 ? bus.req1_int : bus.req0_int;
    sel_tag = gnt1 ? bus.req1_tag : bus.req0_tag;
    // 0x80000000 negates to itself, which is the correct unsigned magnitude 2^31
    mag = sel_int[31] ? -sel_int : sel_int;
    msb = '0;
    for (int i = 0; i < 32; i++) if (mag[i]) msb = 5'(i);
    // left-justify the leading one at bit 31; bits below the 23-bit field are dropped (truncation)
    norm = mag << (5'd31 - msb);
    cvt = mag == '0 ? '0 : {sel_int[31], 8'd127 + 8'(msb), norm[30:8]};
    state_d = gnt ? FULL : bus.res_rdy ? EMPTY : state_q;
    fp_d = gnt ? cvt : fp_q;
    tag_d = gnt ? sel_tag : tag_q;
    src_d = gnt ? gnt1 : src_q;
    last_d = gnt ? gnt1 : last_q;
    cnt_d = cnt_q + CNT_W'(state_q == FULL && bus.res_rdy);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= EMPTY;
      fp_q <= '0;
      tag_q <= '0;
      src_q <= 1'b0;
      last_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fp_q <= fp_d;
      tag_q <= tag_d;
      src_q <= src_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  // the state is already EMPTY in reset, so the grants are gated explicitly to keep rdy low
  assign bus.req0_rdy = rst_n && gnt0;
  assign bus.req1_rdy = rst_n && gnt1;
  assign bus.res_vld = state_q == FULL;
  assign bus.res_fp = fp_q;
  assign bus.res_tag = tag_q;
  assign bus.res_src = src_q;
  assign bus.cvt_cnt = cnt_q;
endmodule

// File: tb/tb_fp_cvt_arbiter.sv
// tb_fp_cvt_arbiter: directed table-driven bench for fp_cvt_arbiter plus an async-reset sequence
module tb_fp_cvt_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  fp_cvt_arbiter_if #(.TAG_W(4), .CNT_W(16)) bus ();
  fp_cvt_arbiter #(.TAG_W(4), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        r0v;
    logic [31:0] r0i;
    logic [3:0]  r0t;
    logic        r1v;
    logic [31:0] r1i;
    logic [3:0]  r1t;
    logic        rr;
    logic        e0;
    logic        e1;
    logic        ev;
    logic [31:0] efp;
    logic [3:0]  etag;
    logic        esrc;
    logic [15:0] ecnt;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic r0v, input logic [31:0] r0i, input logic [3:0] r0t,
                     input logic r1v, input logic [31:0] r1i, input logic [3:0] r1t,
                     input logic rr, input logic e0, input logic e1, input logic ev,
                     input logic [31:0] efp, input logic [3:0] etag, input logic esrc,
                     input logic [15:0] ecnt);
    vec_t v;
    v = '{r0v, r0i, r0t, r1v, r1i, r1t, rr, e0, e1, ev, efp, etag, esrc, ecnt};
    vq.push_back(v);
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic drive(input logic r0v, input logic [31:0] r0i, input logic [3:0] r0t,
                       input logic r1v, input logic [31:0] r1i, input logic [3:0] r1t,
                       input logic rr);
    bus.req0_vld = r0v;
    bus.req0_int = r0i;
    bus.req0_tag = r0t;
    bus.req1_vld = r1v;
    bus.req1_int = r1i;
    bus.req1_tag = r1t;
    bus.res_rdy = rr;
  endtask
  initial begin
    // rows: inputs for this cycle, expected rdy (combinational) and registered outputs before the edge
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00000000, 0, 0, 0);
    add(1, 1, 3, 0, 0, 0, 1, 1, 0, 0, 32'h00000000, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h3F800000, 3, 0, 0);
    add(0, 0, 0, 1, 32'hFFFFFFFF, 5, 1, 0, 1, 0, 32'h3F800000, 3, 0, 1);
    add(0, 0, 0, 1, 32'h80000000, 6, 1, 0, 1, 1, 32'hBF800000, 5, 1, 1);
    add(0, 0, 0, 1, 32'h00000000, 7, 1, 0, 1, 1, 32'hCF000000, 6, 1, 2);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h00000000, 7, 1, 3);
    add(1, 32'h01000001, 1, 1, 32'h7FFFFFFF, 2, 1, 1, 0, 0, 32'h00000000, 7, 1, 4);
    add(1, 32'h01000001, 1, 1, 32'h7FFFFFFF, 2, 1, 0, 1, 1, 32'h4B800000, 1, 0, 4);
    add(1, 32'h01000001, 1, 1, 32'h7FFFFFFF, 2, 1, 1, 0, 1, 32'h4EFFFFFF, 2, 1, 5);
    add(1, 32'h01000001, 1, 1, 32'h7FFFFFFF, 2, 1, 0, 1, 1, 32'h4B800000, 1, 0, 6);
    for (int k = 0; k < 5; k++)
      add(1, 32'h01000001, 1, 1, 32'h7FFFFFFF, 2, 0, 0, 0, 1, 32'h4EFFFFFF, 2, 1, 7);
    add(1, 32'h01000001, 1, 1, 32'h7FFFFFFF, 2, 1, 1, 0, 1, 32'h4EFFFFFF, 2, 1, 7);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h4B800000, 1, 0, 8);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h4B800000, 1, 0, 9);
    add(1, 32'hFFFFFFFB, 4, 0, 0, 0, 0, 1, 0, 0, 32'h4B800000, 1, 0, 9);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC0A00000, 4, 0, 9);
    add(0, 0, 0, 1, 32'h00000003, 9, 0, 0, 0, 1, 32'hC0A00000, 4, 0, 9);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    foreach (vq[i]) begin
      drive(vq[i].r0v, vq[i].r0i, vq[i].r0t, vq[i].r1v, vq[i].r1i, vq[i].r1t, vq[i].rr);
      #1;
      chk($sformatf("row%0d req0_rdy", i), 32'(bus.req0_rdy), 32'(vq[i].e0));
      chk($sformatf("row%0d req1_rdy", i), 32'(bus.req1_rdy), 32'(vq[i].e1));
      chk($sformatf("row%0d res_vld", i), 32'(bus.res_vld), 32'(vq[i].ev));
      chk($sformatf("row%0d res_fp", i), bus.res_fp, vq[i].efp);
      chk($sformatf("row%0d res_tag", i), 32'(bus.res_tag), 32'(vq[i].etag));
      chk($sformatf("row%0d res_src", i), 32'(bus.res_src), 32'(vq[i].esrc));
      chk($sformatf("row%0d cvt_cnt", i), 32'(bus.cvt_cnt), 32'(vq[i].ecnt));
      @(negedge clk);
    end
    // result FULL (0xC0A00000) and unconsumed: pulse reset between edges with both requests pending
    drive(1, 32'h00000003, 8, 1, 32'h00000003, 9, 0);
    #2;
    chk("pre-reset res_vld", 32'(bus.res_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async res_vld", 32'(bus.res_vld), 32'd0);
    chk("async res_fp", bus.res_fp, 32'h0);
    chk("async res_tag", 32'(bus.res_tag), 32'd0);
    chk("async cvt_cnt", 32'(bus.cvt_cnt), 32'd0);
    chk("async req0_rdy", 32'(bus.req0_rdy), 32'd0);
    chk("async req1_rdy", 32'(bus.req1_rdy), 32'd0);
    @(negedge clk);
    chk("reset hold res_vld", 32'(bus.res_vld), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("tie after reset req0_rdy", 32'(bus.req0_rdy), 32'd1);
    chk("tie after reset req1_rdy", 32'(bus.req1_rdy), 32'd0);
    @(posedge clk);
    #1;
    chk("post-reset res_vld", 32'(bus.res_vld), 32'd1);
    chk("post-reset res_fp", bus.res_fp, 32'h40400000);
    chk("post-reset res_tag", 32'(bus.res_tag), 32'd8);
    chk("post-reset res_src", 32'(bus.res_src), 32'd0);
    chk("post-reset cvt_cnt", 32'(bus.cvt_cnt), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fp_cvt_arbiter.md
FP_CVT_ARBITER -- requirements
Module: fp_cvt_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, the width of the requester-supplied tag carried with each conversion.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the completed-conversion counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req0_vld  input  1  requester 0 has a signed integer to convert.
REQ-006 SHALL have port req0_int  input  32  requester 0 signed two's-complement operand.
REQ-007 SHALL have port req0_tag  input  TAG_W  requester 0 tag, returned with the result.
REQ-008 SHALL have port req0_rdy  output  1  requester 0 operand accepted this cycle.
REQ-009 SHALL have ports req1_vld, req1_int, req1_tag, req1_rdy, identical to REQ-005..REQ-008 for requester 1.
REQ-010 SHALL have port res_vld  output  1  result register holds a valid result.
REQ-011 SHALL have port res_fp  output  32  IEEE-754 single-precision result.
REQ-012 SHALL have port res_tag  output  TAG_W  tag of the operand that produced res_fp.
REQ-013 SHALL have port res_src  output  1  requester index (0/1) that produced res_fp.
REQ-014 SHALL have port res_rdy  input  1  consumer takes the result this cycle.
REQ-015 SHALL have port cvt_cnt  output  CNT_W  number of results consumed since reset.

Function
REQ-016 SHALL contain exactly one int-to-float conversion datapath, shared by both requesters.
REQ-017 Conversion SHALL be exact for |x| < 2^24; for larger magnitudes the mantissa SHALL be truncated (round toward zero), never rounded up.
REQ-018 Conversion SHALL map 0 to 0x00000000, 0x80000000 to 0xCF000000, and otherwise set sign = x[31], exponent = 127 + floor(log2|x|).
REQ-019 FSM SHALL have two states: EMPTY (res_vld=0) and FULL (res_vld=1).
REQ-020 Slot free condition: state EMPTY, or state FULL with res_rdy=1.
REQ-021 When the slot is free and at least one reqN_vld=1, exactly one grant SHALL be issued; reqN_rdy=1 only for the granted requester, combinationally in that cycle.
REQ-022 Single request: grant that requester; both requesting: grant the requester not granted most recently (round-robin); last-grant pointer resets to 1 so requester 0 wins the first tie.
REQ-023 On grant, result register SHALL load converted value, tag and source at the next rising edge; state becomes FULL (latency 1 cycle, throughput 1 per cycle).
REQ-024 FULL with res_rdy=1 and no request: state SHALL go EMPTY; FULL with res_rdy=0: res_fp, res_tag, res_src SHALL hold stable and both reqN_rdy SHALL be 0.
REQ-025 reqN_rdy SHALL never depend on reqN_vld of the same requester combinationally except through the grant; reqN_rdy=0 when reqN_vld=0.
REQ-026 Last-grant pointer SHALL update only on a cycle in which a grant is issued.
REQ-027 cvt_cnt SHALL increment by 1 on each cycle with res_vld=1 and res_rdy=1, wrapping from all-ones to 0.
REQ-028 res_rdy=1 while EMPTY SHALL have no effect.

Reset
REQ-029 On rst_n=0, immediately and regardless of clk: state EMPTY, res_vld=0, res_fp=0, res_tag=0, res_src=0, cvt_cnt=0, last-grant pointer=1.
REQ-030 Reset asserted while FULL SHALL discard the held result without incrementing cvt_cnt.
REQ-031 req0_rdy and req1_rdy SHALL be 0 while rst_n=0.

Verification
REQ-032 req0_vld=1, req0_int=1, tag=3, res_rdy=1 -> next cycle res_vld=1, res_fp=0x3F800000, res_tag=3, res_src=0, then cvt_cnt=1.
REQ-033 req1_int=0xFFFFFFFF (-1), then 0x80000000, then 0 back-to-back, res_rdy=1 -> results 0xBF800000, 0xCF000000, 0x00000000 on consecutive cycles, res_src=1.
REQ-034 Both requesters valid every cycle, res_rdy=1, after reset -> grants alternate 0,1,0,1; res_src sequence 0,1,0,1.
REQ-035 req0_int=0x01000001 (2^24+1) -> res_fp=0x4B800000 (truncated); req0_int=0x7FFFFFFF -> 0x4EFFFFFF.
REQ-036 Result FULL, res_rdy=0 for 5 cycles with both requests valid -> both reqN_rdy=0, res_fp stable; res_rdy=1 -> next grant follows round-robin, cvt_cnt +1.
REQ-037 rst_n pulsed low mid-cycle while FULL -> res_vld=0 and cvt_cnt=0 before next clk edge; first tie after release grants requester 0.
